dma_fifo_ctrl: RTL and testbench

//  Pointer/flag controller and first-word-fall-through front end for the DMA controller's 2-port SRAM FIFO.

---
 rtl/dma_fifo_pkg.sv | 25 ++
 rtl/dma_fifo_skid.sv | 79 +++++++
 rtl/dma_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_dma_fifo_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_fifo_pkg.sv
// dma_fifo_pkg: sizing helpers shared by the DMA FIFO controller, its skid buffer
// and the RAM wrapper instantiation.
package dma_fifo_pkg;

    // Number of RAM entries for a given address width.
    function automatic int unsigned depth_f(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Skid entries needed to absorb every read that can be in flight.
    function automatic int unsigned skid_depth_f(input int unsigned rd_latency);
        return rd_latency + 32'd1;
    endfunction

    // LEVEL width: RAM occupancy plus skid/in-flight words, up to DEPTH+SKID_DEPTH.
    function automatic int unsigned level_w_f(input int unsigned addr_w);
        return addr_w + 32'd2;
    endfunction

    // Width of a counter that must hold the values 0..n.
    function automatic int unsigned cnt_w_f(input int unsigned n);
        return $clog2(n + 32'd1);
    endfunction

endpackage

// File: rtl/dma_fifo_skid.sv
// dma_fifo_skid: small registered FIFO that holds RAM read data so the
// downstream side sees first-word-fall-through behaviour.
module dma_fifo_skid
    import dma_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned SKID_DEPTH = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [WIDTH-1:0]                  push_data,
    input  logic                              pop,
    output logic [cnt_w_f(SKID_DEPTH)-1:0]    count,
    output logic [WIDTH-1:0]                  head
);
    localparam int unsigned CNT_W = cnt_w_f(SKID_DEPTH);
    localparam int unsigned IDX_W = $clog2(SKID_DEPTH);

    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [WIDTH-1:0] mem_d [SKID_DEPTH];
    logic             do_pop;
    logic             full;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(SKID_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign do_pop = pop && (count_q != '0);
    assign full   = (count_q == CNT_W'(SKID_DEPTH));
    assign count  = count_q;
    assign head   = mem_q[rd_idx_q];

    // Next-state for the ring indices and occupancy; push and pop may coincide.
    always_comb begin
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        if (push) begin
            wr_idx_d = next_idx(wr_idx_q);
        end
        if (do_pop) begin
            rd_idx_d = next_idx(rd_idx_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end

    // Storage update: write the incoming word at the tail.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_idx_q] = push_data;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            count_q  <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
        end
    end

    // Data storage registers; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // The upstream credit check must never let a word arrive with no room.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/dma_fifo_ctrl.sv
// dma_fifo_ctrl: pointer/flag controller for the DMA 2-port SRAM FIFO with a
// skid-buffered first-word-fall-through read side.
module dma_fifo_ctrl
    import dma_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                           CLOCK,
    input  logic                           RESET,
    input  logic                           WR_VALID,
    output logic                           WR_READY,
    input  logic [WIDTH-1:0]               WR_DATA,
    output logic                           RAM_WEN,
    output logic [ADDR_W-1:0]              RAM_WADDR,
    output logic [WIDTH-1:0]               RAM_WDATA,
    output logic                           RAM_REN,
    output logic [ADDR_W-1:0]              RAM_RADDR,
    input  logic [WIDTH-1:0]               RAM_RDATA,
    output logic                           RD_VALID,
    input  logic                           RD_READY,
    output logic [WIDTH-1:0]               RD_DATA,
    output logic                           FULL,
    output logic                           EMPTY,
    output logic [level_w_f(ADDR_W)-1:0]   LEVEL
);
    localparam int unsigned DEPTH      = depth_f(ADDR_W);
    localparam int unsigned SKID_DEPTH = skid_depth_f(RD_LATENCY);
    localparam int unsigned CNT_W      = cnt_w_f(SKID_DEPTH);
    localparam int unsigned SUM_W      = CNT_W + 1;
    localparam int unsigned PTR_W      = ADDR_W + 1;
    localparam int unsigned LEVEL_W    = level_w_f(ADDR_W);

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [LEVEL_W-1:0]    level_q, level_d;

    logic [PTR_W-1:0]      occ;
    logic                  full;
    logic                  wr_hs;
    logic                  rd_hs;
    logic                  ren;
    logic [CNT_W-1:0]      inflight_cnt;
    logic [CNT_W-1:0]      skid_count;
    logic [SUM_W-1:0]      committed;
    logic [SUM_W-1:0]      credit_limit;

    // RAM occupancy from registered pointers; the wrap bit separates full from empty.
    assign occ   = wptr_q - rptr_q;
    assign full  = (occ == PTR_W'(DEPTH));
    assign wr_hs = WR_VALID && !full;
    assign rd_hs = RD_VALID && RD_READY;

    // A pop this cycle frees a skid slot before any newly issued read can land,
    // so it counts as credit; this keeps one read per cycle in steady state.
    assign committed    = SUM_W'(inflight_cnt) + SUM_W'(skid_count);
    assign credit_limit = SUM_W'(SKID_DEPTH) + SUM_W'(rd_hs);
    assign ren          = (occ != '0) && (committed < credit_limit);

    assign WR_READY  = !full;
    assign FULL      = full;
    assign RAM_WEN   = wr_hs;
    assign RAM_WADDR = wptr_q[ADDR_W-1:0];
    assign RAM_WDATA = WR_DATA;
    assign RAM_REN   = ren;
    assign RAM_RADDR = rptr_q[ADDR_W-1:0];
    assign RD_VALID  = (skid_count != '0);
    assign EMPTY     = (level_q == '0);
    assign LEVEL     = level_q;

    // Count reads currently travelling through the RAM pipeline.
    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
        end
    end

    // Shift a valid marker alongside each issued read until its data returns.
    always_comb begin
        inflight_d    = '0;
        inflight_d[0] = ren;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
    end

    // Pointer and level next-state.
    always_comb begin
        wptr_d  = wptr_q + PTR_W'(wr_hs);
        rptr_d  = rptr_q + PTR_W'(ren);
        level_d = level_q + LEVEL_W'(wr_hs) - LEVEL_W'(rd_hs);
    end

    // State registers; clearing the in-flight markers drops any returning read data.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= '0;
            level_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            level_q    <= level_d;
        end
    end

    dma_fifo_skid #(
        .WIDTH      (WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (CLOCK),
        .rst       (RESET),
        .push      (inflight_q[RD_LATENCY-1]),
        .push_data (RAM_RDATA),
        .pop       (rd_hs),
        .count     (skid_count),
        .head      (RD_DATA)
    );

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// tb_dma_fifo_ctrl: scenario bench for dma_fifo_ctrl with a 2-cycle-read RAM model
// and a queue-based reference of the FIFO contents.
module tb_dma_fifo_ctrl;
    localparam int unsigned W     = 128;
    localparam int unsigned AW    = 7;
    localparam int unsigned LAT   = 2;
    localparam int          DEPTH = 128;
    localparam int          SKID  = 3;
    localparam int unsigned LW    = 9;

    logic          CLOCK;
    logic          RESET;
    logic          WR_VALID;
    logic          WR_READY;
    logic [W-1:0]  WR_DATA;
    logic          RAM_WEN;
    logic [AW-1:0] RAM_WADDR;
    logic [W-1:0]  RAM_WDATA;
    logic          RAM_REN;
    logic [AW-1:0] RAM_RADDR;
    logic [W-1:0]  RAM_RDATA;
    logic          RD_VALID;
    logic          RD_READY;
    logic [W-1:0]  RD_DATA;
    logic          FULL;
    logic          EMPTY;
    logic [LW-1:0] LEVEL;

    dma_fifo_ctrl #(
        .WIDTH      (W),
        .ADDR_W     (AW),
        .RD_LATENCY (LAT)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .WR_VALID  (WR_VALID),
        .WR_READY  (WR_READY),
        .WR_DATA   (WR_DATA),
        .RAM_WEN   (RAM_WEN),
        .RAM_WADDR (RAM_WADDR),
        .RAM_WDATA (RAM_WDATA),
        .RAM_REN   (RAM_REN),
        .RAM_RADDR (RAM_RADDR),
        .RAM_RDATA (RAM_RDATA),
        .RD_VALID  (RD_VALID),
        .RD_READY  (RD_READY),
        .RD_DATA   (RD_DATA),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .LEVEL     (LEVEL)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Behavioural 2-port RAM: address registered on issue, data registered one cycle later.
    logic [W-1:0]  ram [DEPTH];
    logic [AW-1:0] ram_addr_r;
    logic [W-1:0]  ram_data_r;
    always @(posedge CLOCK) begin
        if (RAM_WEN === 1'b1) ram[RAM_WADDR] <= RAM_WDATA;
        if (RAM_REN === 1'b1) ram_addr_r <= RAM_RADDR;
        ram_data_r <= ram[ram_addr_r];
    end
    assign RAM_RDATA = ram_data_r;

    // Reference: ordered contents plus counts of handshakes since reset.
    logic [W-1:0] sb [$];
    int level_m, wr_total, ren_total;
    int vectors, miscompares;

    // Per-cycle samples taken on the falling edge.
    logic          s_wr_ready, s_rd_valid, s_ren, s_wen, s_full, s_empty;
    logic          s_wr_hs, s_rd_hs;
    logic [LW-1:0] s_level;
    logic [W-1:0]  s_rd_data, s_exp_data;
    logic [AW-1:0] s_waddr, s_raddr;
    int            s_exp_level, s_exp_waddr, s_exp_raddr;

    function automatic logic [W-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock cycle: apply inputs, sample outputs, advance the reference.
    task automatic step(input logic wv, input logic [W-1:0] wd, input logic rr);
        WR_VALID = wv;
        WR_DATA  = wd;
        RD_READY = rr;
        @(negedge CLOCK);
        s_wr_ready  = WR_READY;
        s_rd_valid  = RD_VALID;
        s_ren       = RAM_REN;
        s_wen       = RAM_WEN;
        s_full      = FULL;
        s_empty     = EMPTY;
        s_level     = LEVEL;
        s_rd_data   = RD_DATA;
        s_waddr     = RAM_WADDR;
        s_raddr     = RAM_RADDR;
        s_exp_level = level_m;
        s_exp_waddr = wr_total % DEPTH;
        s_exp_raddr = ren_total % DEPTH;
        s_wr_hs     = wv && (s_wr_ready === 1'b1);
        s_rd_hs     = rr && (s_rd_valid === 1'b1);
        s_exp_data  = 'x;
        if (s_rd_hs && sb.size() != 0) s_exp_data = sb[0];
        if (RESET) begin
            sb.delete();
            level_m   = 0;
            wr_total  = 0;
            ren_total = 0;
        end else begin
            if (s_rd_hs && sb.size() != 0) void'(sb.pop_front());
            if (s_wr_hs) sb.push_back(wd);
            level_m   = level_m + int'(s_wr_hs) - int'(s_rd_hs);
            wr_total  = wr_total + int'(s_wr_hs);
            ren_total = ren_total + int'(s_ren === 1'b1);
        end
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        RESET = 1'b0;
        step(1'b0, '0, 1'b1);
        vectors++; if (s_wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b expected 1", s_wr_ready); end
        vectors++; if (s_wen !== 1'b0) begin miscompares++; $display("FAIL reset_ram_wen: got %b expected 0", s_wen); end
        vectors++; if (s_ren !== 1'b0) begin miscompares++; $display("FAIL reset_ram_ren: got %b expected 0", s_ren); end
        vectors++; if (s_rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b expected 0", s_rd_valid); end
        vectors++; if (s_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", s_full); end
        vectors++; if (s_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", s_empty); end
        vectors++; if (s_level !== LW'(0)) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", s_level); end
        // Read-ready into an empty FIFO must change nothing.
        step(1'b0, '0, 1'b1);
        vectors++; if (s_level !== LW'(0) || s_rd_valid !== 1'b0) begin
            miscompares++; $display("FAIL idle_ready: got level %0d valid %b expected 0 0", s_level, s_rd_valid);
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] pat;
        int exp_ren [5];
        int exp_val [5];
        int exp_lvl [5];
        pat     = {16{8'hA5}};
        exp_ren = '{1, 0, 0, 0, 0};
        exp_val = '{0, 0, 0, 1, 0};
        exp_lvl = '{1, 1, 1, 1, 0};
        step(1'b1, pat, 1'b1);
        vectors++; if (s_wen !== 1'b1 || s_waddr !== AW'(0)) begin
            miscompares++; $display("FAIL single_write: got wen %b addr %0d expected 1 0", s_wen, s_waddr);
        end
        vectors++; if (s_level !== LW'(0)) begin miscompares++; $display("FAIL single_level0: got %0d expected 0", s_level); end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b1);
            vectors++; if (s_ren !== 1'(exp_ren[k])) begin
                miscompares++; $display("FAIL single_ren c%0d: got %b expected %0d", k + 1, s_ren, exp_ren[k]);
            end
            vectors++; if (s_rd_valid !== 1'(exp_val[k])) begin
                miscompares++; $display("FAIL single_valid c%0d: got %b expected %0d", k + 1, s_rd_valid, exp_val[k]);
            end
            vectors++; if (s_level !== LW'(exp_lvl[k])) begin
                miscompares++; $display("FAIL single_level c%0d: got %0d expected %0d", k + 1, s_level, exp_lvl[k]);
            end
            if (s_rd_hs) begin
                vectors++; if (s_rd_data !== pat) begin miscompares++; $display("FAIL single_data: got %h expected %h", s_rd_data, pat); end
            end
        end
    endtask

    task automatic test_fill();
        int acc = 0;
        int rens = 0;
        int n = 0;
        while (n < 300) begin
            step(1'b1, rnd_word(), 1'b0);
            vectors++; if (s_level !== LW'(s_exp_level)) begin
                miscompares++; $display("FAIL fill_level: got %0d expected %0d", s_level, s_exp_level);
            end
            acc  = acc + int'(s_wr_hs);
            rens = rens + int'(s_ren === 1'b1);
            if (s_wr_ready !== 1'b1) break;
            n++;
        end
        vectors++; if (acc != DEPTH + SKID) begin miscompares++; $display("FAIL fill_accepted: got %0d expected %0d", acc, DEPTH + SKID); end
        vectors++; if (rens != SKID) begin miscompares++; $display("FAIL fill_reads_issued: got %0d expected %0d", rens, SKID); end
        vectors++; if (s_level !== LW'(DEPTH + SKID)) begin miscompares++; $display("FAIL fill_level_max: got %0d expected %0d", s_level, DEPTH + SKID); end
        vectors++; if (s_full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b expected 1", s_full); end
        // Writes offered while full must be refused and not issue reads.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, rnd_word(), 1'b0);
            vectors++; if (s_wr_ready !== 1'b0 || s_ren !== 1'b0 || s_level !== LW'(DEPTH + SKID)) begin
                miscompares++; $display("FAIL full_hold: got ready %b ren %b level %0d expected 0 0 %0d", s_wr_ready, s_ren, s_level, DEPTH + SKID);
            end
        end
    endtask

    task automatic test_full_with_read();
        step(1'b1, rnd_word(), 1'b1);
        vectors++; if (s_wr_ready !== 1'b0) begin miscompares++; $display("FAIL fwr_same_cycle_ready: got %b expected 0", s_wr_ready); end
        vectors++; if (s_rd_valid !== 1'b1 || s_rd_data !== s_exp_data) begin
            miscompares++; $display("FAIL fwr_read: got valid %b data %h expected 1 %h", s_rd_valid, s_rd_data, s_exp_data);
        end
        step(1'b1, rnd_word(), 1'b0);
        vectors++; if (s_wr_ready !== 1'b1) begin miscompares++; $display("FAIL fwr_next_cycle_ready: got %b expected 1", s_wr_ready); end
        vectors++; if (s_level !== LW'(DEPTH + SKID - 1)) begin
            miscompares++; $display("FAIL fwr_level_dip: got %0d expected %0d", s_level, DEPTH + SKID - 1);
        end
        step(1'b0, '0, 1'b0);
        vectors++; if (s_level !== LW'(DEPTH + SKID) || s_full !== 1'b1) begin
            miscompares++; $display("FAIL fwr_refill: got level %0d full %b expected %0d 1", s_level, s_full, DEPTH + SKID);
        end
    endtask

    task automatic test_drain();
        int n = 0;
        while (level_m != 0 && n < 400) begin
            step(1'b0, '0, 1'b1);
            vectors++; if (s_level !== LW'(s_exp_level)) begin
                miscompares++; $display("FAIL drain_level: got %0d expected %0d", s_level, s_exp_level);
            end
            if (s_rd_hs) begin
                vectors++; if (s_rd_data !== s_exp_data) begin miscompares++; $display("FAIL drain_data: got %h expected %h", s_rd_data, s_exp_data); end
            end
            n++;
        end
        vectors++; if (level_m != 0) begin miscompares++; $display("FAIL drain_timeout: got %0d left expected 0", level_m); end
        step(1'b0, '0, 1'b1);
        vectors++; if (s_empty !== 1'b1 || s_rd_valid !== 1'b0) begin
            miscompares++; $display("FAIL drain_empty: got empty %b valid %b expected 1 0", s_empty, s_rd_valid);
        end
    endtask

    task automatic test_stream();
        int first_pop = -1;
        int last_pop = -1;
        int pops = 0;
        int i = 0;
        while ((i < 300 || sb.size() != 0) && i < 400) begin
            step(i < 300, W'(i) + W'(32'h1000), 1'b1);
            if (i < 300) begin
                vectors++; if (s_wr_ready !== 1'b1) begin miscompares++; $display("FAIL stream_wr_ready c%0d: got %b expected 1", i, s_wr_ready); end
            end
            if (s_wr_hs) begin
                vectors++; if (s_waddr !== AW'(s_exp_waddr)) begin miscompares++; $display("FAIL stream_waddr: got %0d expected %0d", s_waddr, s_exp_waddr); end
            end
            if (s_ren === 1'b1) begin
                vectors++; if (s_raddr !== AW'(s_exp_raddr)) begin miscompares++; $display("FAIL stream_raddr: got %0d expected %0d", s_raddr, s_exp_raddr); end
            end
            vectors++; if (s_level !== LW'(s_exp_level)) begin miscompares++; $display("FAIL stream_level: got %0d expected %0d", s_level, s_exp_level); end
            if (s_rd_hs) begin
                vectors++; if (s_rd_data !== s_exp_data) begin miscompares++; $display("FAIL stream_data: got %h expected %h", s_rd_data, s_exp_data); end
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                pops++;
            end
            i++;
        end
        vectors++; if (first_pop != 2 + int'(LAT)) begin miscompares++; $display("FAIL stream_latency: got %0d expected %0d", first_pop, 2 + LAT); end
        vectors++; if (pops != 300) begin miscompares++; $display("FAIL stream_count: got %0d expected 300", pops); end
        vectors++; if (last_pop != 301 + int'(LAT)) begin miscompares++; $display("FAIL stream_gapless: got last %0d expected %0d", last_pop, 301 + LAT); end
    endtask

    task automatic test_random();
        int written = 0;
        int starve = 0;
        int n = 0;
        logic wv;
        while ((written < 10000 || sb.size() != 0) && n < 60000) begin
            wv = (written < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            step(wv, rnd_word(), 1'($urandom_range(0, 1)));
            written = written + int'(s_wr_hs);
            vectors++; if (s_level !== LW'(s_exp_level)) begin miscompares++; $display("FAIL rand_level: got %0d expected %0d", s_level, s_exp_level); end
            vectors++; if (s_empty !== (s_exp_level == 0)) begin miscompares++; $display("FAIL rand_empty: got %b expected %b", s_empty, s_exp_level == 0); end
            if (s_exp_level < DEPTH) begin
                vectors++; if (s_wr_ready !== 1'b1) begin miscompares++; $display("FAIL rand_wr_ready: got %b expected 1", s_wr_ready); end
            end
            if (s_rd_hs) begin
                vectors++; if (s_rd_data !== s_exp_data) begin miscompares++; $display("FAIL rand_data: got %h expected %h", s_rd_data, s_exp_data); end
            end
            starve = (s_exp_level != 0 && s_rd_valid !== 1'b1) ? starve + 1 : 0;
            vectors++; if (starve > 8) begin miscompares++; $display("FAIL rand_starve: got %0d idle cycles expected <= 8", starve); starve = 0; end
            n++;
        end
        vectors++; if (written != 10000 || sb.size() != 0) begin
            miscompares++; $display("FAIL rand_timeout: got %0d written %0d left expected 10000 0", written, sb.size());
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] x;
        int got_at = -1;
        for (int k = 0; k < 3; k++) step(1'b1, rnd_word(), 1'b0);
        step(1'b0, '0, 1'b0);
        RESET = 1'b1;
        step(1'b0, '0, 1'b0);
        RESET = 1'b0;
        vectors++; if (s_rd_valid !== 1'b1 || s_level !== LW'(3)) begin
            miscompares++; $display("FAIL midop_pre: got valid %b level %0d expected 1 3", s_rd_valid, s_level);
        end
        step(1'b0, '0, 1'b1);
        vectors++; if (s_rd_valid !== 1'b0 || s_level !== LW'(0) || s_empty !== 1'b1) begin
            miscompares++; $display("FAIL midop_post: got valid %b level %0d empty %b expected 0 0 1", s_rd_valid, s_level, s_empty);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0, 1'b1);
            vectors++; if (s_rd_valid !== 1'b0 || s_ren !== 1'b0) begin
                miscompares++; $display("FAIL midop_late_data c%0d: got valid %b ren %b expected 0 0", k, s_rd_valid, s_ren);
            end
        end
        x = rnd_word();
        step(1'b1, x, 1'b1);
        vectors++; if (s_wen !== 1'b1 || s_waddr !== AW'(0)) begin
            miscompares++; $display("FAIL midop_waddr: got wen %b addr %0d expected 1 0", s_wen, s_waddr);
        end
        for (int k = 1; k <= 10 && got_at < 0; k++) begin
            step(1'b0, '0, 1'b1);
            if (s_ren === 1'b1) begin
                vectors++; if (s_raddr !== AW'(0)) begin miscompares++; $display("FAIL midop_raddr: got %0d expected 0", s_raddr); end
            end
            if (s_rd_hs) begin
                got_at = k;
                vectors++; if (s_rd_data !== x) begin miscompares++; $display("FAIL midop_data: got %h expected %h", s_rd_data, x); end
            end
        end
        vectors++; if (got_at != 2 + int'(LAT)) begin miscompares++; $display("FAIL midop_latency: got %0d expected %0d", got_at, 2 + LAT); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RESET       = 1'b1;
        WR_VALID    = 1'b0;
        WR_DATA     = '0;
        RD_READY    = 1'b0;
        vectors     = 0;
        miscompares = 0;
        level_m     = 0;
        wr_total    = 0;
        ren_total   = 0;
        test_reset();
        test_single_word();
        test_fill();
        test_full_with_read();
        test_drain();
        test_stream();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
